// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: register-file geometry and
// write-enable polarity.
package hazard_scoreboard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned INFLIGHT_W = 3;

   // Pipeline write enable is active-low.
   localparam logic WB_ON  = 1'b0;
   localparam logic WB_OFF = 1'b1;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register saturating up/down counter of outstanding long-latency writes.
// Simultaneous inc and dec leave the count unchanged.
module sb_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;

   always_comb begin
      w_cnt_d = r_cnt;
      if (inc_i && !dec_i && !sat_o) begin
         w_cnt_d = r_cnt + CNT_W'(1);
      end else if (dec_i && !inc_i && !zero_o) begin
         w_cnt_d = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign cnt_o  = r_cnt;
   assign sat_o  = &r_cnt;
   assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks pending long-latency register writes and stalls ID on RAW/capacity hazards.
// Optional WAW stall is enabled by defining SCOREBOARD_WAW_CHECK_EN.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned CNT_W        = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   input  logic                  issue_wb_i,
   input  logic                  issue_long_i,
   input  logic                  flush_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic                  retire_valid_i,
   input  logic [REG_ADDR_W-1:0] retire_rd_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  err_o
);

   logic [CNT_W-1:0]      w_cnt [NUM_REGS];
   logic [NUM_REGS-1:0]   w_sat;
   logic [NUM_REGS-1:0]   w_zero;
   logic [NUM_REGS-1:1]   w_inc;
   logic [NUM_REGS-1:1]   w_dec;
   logic [INFLIGHT_W-1:0] r_inflight;
   logic [INFLIGHT_W-1:0] w_inflight_d;
   logic                  r_busy;
   logic                  r_err;
   logic w_ret_ok, w_hit_rs1, w_hit_rs2, w_hit_rd;
   logic w_src_stall, w_cap_stall, w_waw_stall, w_write_long, w_accept;

   // x0 is never tracked and always reads as an empty count.
   assign w_cnt[0]  = '0;
   assign w_sat[0]  = 1'b0;
   assign w_zero[0] = 1'b1;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
      assign w_inc[g] = w_accept && (issue_rd_i == REG_ADDR_W'(g));
      assign w_dec[g] = w_ret_ok && (retire_rd_i == REG_ADDR_W'(g));
      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .inc_i   (w_inc[g]),
         .dec_i   (w_dec[g]),
         .cnt_o   (w_cnt[g]),
         .sat_o   (w_sat[g]),
         .zero_o  (w_zero[g])
      );
   end

   assign w_ret_ok = retire_valid_i && (retire_rd_i != '0) && !w_zero[retire_rd_i];

   // Last outstanding write retiring now reaches EX via WB forwarding: no stall.
   assign w_hit_rs1 = retire_valid_i && (retire_rd_i == rs1_i) && (w_cnt[rs1_i] == CNT_W'(1));
   assign w_hit_rs2 = retire_valid_i && (retire_rd_i == rs2_i) && (w_cnt[rs2_i] == CNT_W'(1));
   assign w_hit_rd  = retire_valid_i && (retire_rd_i == issue_rd_i) &&
                      (w_cnt[issue_rd_i] == CNT_W'(1));

   assign w_src_stall = (rs1_used_i && (rs1_i != '0) && !w_zero[rs1_i] && !w_hit_rs1) ||
                        (rs2_used_i && (rs2_i != '0) && !w_zero[rs2_i] && !w_hit_rs2);

   assign w_write_long = issue_long_i && (issue_wb_i == WB_ON);

   // Capacity: global in-flight limit, or a per-register counter already saturated.
   assign w_cap_stall = w_write_long &&
                        (((r_inflight == INFLIGHT_W'(MAX_INFLIGHT)) && !w_ret_ok) ||
                         (w_sat[issue_rd_i] && !(w_ret_ok && (retire_rd_i == issue_rd_i))));

`ifdef SCOREBOARD_WAW_CHECK_EN
   assign w_waw_stall = (issue_wb_i == WB_ON) && (issue_rd_i != '0) &&
                        !w_zero[issue_rd_i] && !w_hit_rd;
`else
   assign w_waw_stall = 1'b0;
   logic w_unused_hit_rd;
   assign w_unused_hit_rd = w_hit_rd;
`endif

   assign stall_o  = issue_valid_i && (w_src_stall || w_cap_stall || w_waw_stall);
   assign w_accept = issue_valid_i && !stall_o && !flush_i && w_write_long &&
                     (issue_rd_i != '0);

   always_comb begin
      w_inflight_d = r_inflight;
      if (w_accept && !w_ret_ok) begin
         w_inflight_d = r_inflight + INFLIGHT_W'(1);
      end else if (w_ret_ok && !w_accept) begin
         w_inflight_d = r_inflight - INFLIGHT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_inflight <= '0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_inflight <= w_inflight_d;
         r_busy     <= (w_inflight_d != '0);
         r_err      <= retire_valid_i && !w_ret_ok;
      end
   end

   assign busy_o = r_busy;
   assign err_o  = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (MAX_INFLIGHT=4, CNT_W=2).
// Honours SCOREBOARD_WAW_CHECK_EN in the WAW and saturation steps.
module tb_hazard_scoreboard;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       issue_valid_i;
   logic [4:0] issue_rd_i;
   logic       issue_wb_i;
   logic       issue_long_i;
   logic       flush_i;
   logic [4:0] rs1_i;
   logic [4:0] rs2_i;
   logic       rs1_used_i;
   logic       rs2_used_i;
   logic       retire_valid_i;
   logic [4:0] retire_rd_i;
   logic       stall_o;
   logic       busy_o;
   logic       err_o;

   int n_vec = 0;
   int n_err = 0;

`ifdef SCOREBOARD_WAW_CHECK_EN
   localparam bit WAW = 1'b1;
`else
   localparam bit WAW = 1'b0;
`endif

   hazard_scoreboard #(
      .MAX_INFLIGHT (4),
      .CNT_W        (2)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .issue_valid_i  (issue_valid_i),
      .issue_rd_i     (issue_rd_i),
      .issue_wb_i     (issue_wb_i),
      .issue_long_i   (issue_long_i),
      .flush_i        (flush_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .rs1_used_i     (rs1_used_i),
      .rs2_used_i     (rs2_used_i),
      .retire_valid_i (retire_valid_i),
      .retire_rd_i    (retire_rd_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      issue_valid_i  = 1'b0;
      issue_rd_i     = '0;
      issue_wb_i     = 1'b1;
      issue_long_i   = 1'b0;
      flush_i        = 1'b0;
      rs1_i          = '0;
      rs2_i          = '0;
      rs1_used_i     = 1'b0;
      rs2_used_i     = 1'b0;
      retire_valid_i = 1'b0;
      retire_rd_i    = '0;
   endtask

   // Long-latency write to rd; source operands unused.
   task automatic long_issue(input logic [4:0] rd);
      idle();
      issue_valid_i = 1'b1;
      issue_rd_i    = rd;
      issue_wb_i    = 1'b0;
      issue_long_i  = 1'b1;
   endtask

   // Non-writing instruction reading rs1.
   task automatic reader(input logic [4:0] rs);
      idle();
      issue_valid_i = 1'b1;
      rs1_i         = rs;
      rs1_used_i    = 1'b1;
   endtask

   task automatic retire(input logic [4:0] rd);
      retire_valid_i = 1'b1;
      retire_rd_i    = rd;
   endtask

   initial begin
      idle();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      #1;
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_err", err_o, 1'b0);
      chk("reset_stall", stall_o, 1'b0);

      // RAW on a long load to x5, released in the retire cycle
      long_issue(5'd5);
      #1 chk("raw_issue_stall", stall_o, 1'b0);
      tick();
      chk("raw_busy", busy_o, 1'b1);
      reader(5'd5);
      #1 chk("raw_dep_stall", stall_o, 1'b1);
      tick();
      #1 chk("raw_dep_stall2", stall_o, 1'b1);
      retire(5'd5);
      #1 chk("raw_retire_release", stall_o, 1'b0);
      tick();
      chk("raw_busy_clear", busy_o, 1'b0);
      chk("raw_no_err", err_o, 1'b0);
      reader(5'd5);
      #1 chk("raw_after_stall", stall_o, 1'b0);

      // Fill to capacity, then a fifth issue paired with a retire
      for (int r = 1; r <= 4; r++) begin
         long_issue(5'(r));
         #1 chk("fill_stall", stall_o, 1'b0);
         tick();
      end
      long_issue(5'd6);
      #1 chk("cap_stall", stall_o, 1'b1);
      retire(5'd2);
      #1 chk("cap_release_on_retire", stall_o, 1'b0);
      tick();
      long_issue(5'd8);
      #1 chk("cap_still_full", stall_o, 1'b1);
      reader(5'd2);
      #1 chk("cap_rd2_free", stall_o, 1'b0);
      reader(5'd6);
      #1 chk("cap_rd6_pending", stall_o, 1'b1);
      idle();
      retire(5'd1);
      tick();
      retire(5'd3);
      tick();
      retire(5'd4);
      tick();
      chk("drain_busy_partial", busy_o, 1'b1);
      retire(5'd6);
      tick();
      chk("drain_busy", busy_o, 1'b0);
      chk("drain_err", err_o, 1'b0);

      // x0 is never tracked; retire to x0 is a protocol error
      long_issue(5'd0);
      rs1_i      = 5'd0;
      rs1_used_i = 1'b1;
      #1 chk("x0_no_stall", stall_o, 1'b0);
      tick();
      chk("x0_not_busy", busy_o, 1'b0);
      idle();
      retire(5'd0);
      tick();
      chk("x0_retire_err", err_o, 1'b1);
      idle();
      tick();
      chk("x0_err_pulse", err_o, 1'b0);

      // Flushed issue is not recorded
      long_issue(5'd7);
      flush_i = 1'b1;
      tick();
      chk("flush_not_busy", busy_o, 1'b0);
      reader(5'd7);
      #1 chk("flush_no_raw", stall_o, 1'b0);
      idle();
      retire(5'd7);
      tick();
      chk("flush_retire_err", err_o, 1'b1);
      chk("flush_retire_busy", busy_o, 1'b0);
      idle();
      tick();
      chk("flush_err_pulse", err_o, 1'b0);

      // Two writes to x9
      long_issue(5'd9);
      tick();
      long_issue(5'd9);
      #1 chk("waw_second", stall_o, WAW);
      if (WAW) begin
         retire(5'd9);
         #1 chk("waw_release_on_retire", stall_o, 1'b0);
         tick();
         reader(5'd9);
         #1 chk("waw_raw_second", stall_o, 1'b1);
         retire(5'd9);
         #1 chk("waw_raw_release", stall_o, 1'b0);
         tick();
      end else begin
         tick();
         reader(5'd9);
         #1 chk("cnt2_raw", stall_o, 1'b1);
         retire(5'd9);
         #1 chk("cnt2_retire_first", stall_o, 1'b1);
         tick();
         chk("cnt2_busy", busy_o, 1'b1);
         reader(5'd9);
         retire(5'd9);
         #1 chk("cnt2_retire_second", stall_o, 1'b0);
         tick();
      end
      chk("x9_busy_clear", busy_o, 1'b0);
      chk("x9_no_err", err_o, 1'b0);

      // Three in flight, then reset discards them
      if (WAW) begin
         for (int r = 10; r <= 12; r++) begin
            long_issue(5'(r));
            tick();
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            long_issue(5'd10);
            tick();
         end
         long_issue(5'd10);
         #1 chk("sat_stall", stall_o, 1'b1);
      end
      reader(5'd10);
      #1 chk("pre_reset_stall", stall_o, 1'b1);
      chk("pre_reset_busy", busy_o, 1'b1);
      idle();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("post_reset_busy", busy_o, 1'b0);
      reader(5'd10);
      #1 chk("post_reset_stall", stall_o, 1'b0);
      idle();
      retire(5'd10);
      tick();
      chk("post_reset_retire_err", err_o, 1'b1);
      idle();
      tick();
      chk("post_reset_err_pulse", err_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
